// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if
//   Bundles the write-back request channels, the issue/decode hazard signals
//   and the register-file write port of the write-back scheduler.
//
//   master : the execute/memory/decode side plus the register file observer
//            (drives requests, issue and source indices; sees grants, busy
//            flags and the registered write port)
//   slave  : the scheduler itself
//
//   Signals
//     alu_valid/alu_rd/alu_data -> alu_ready   ALU write-back request
//     lsu_valid/lsu_rd/lsu_data -> lsu_ready   LSU load write-back request
//     issue_valid/issue_rd      -> issue_ready destination reservation
//     rs1/rs2                   -> rs1_busy/rs2_busy  source hazard query
//     rf_write/rf_rd/rf_rddata                 register-file write port
interface regfile_wb_sched_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int IDX_W = $clog2(NREG);

  logic             alu_valid;
  logic [IDX_W-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             alu_ready;

  logic             lsu_valid;
  logic [IDX_W-1:0] lsu_rd;
  logic [XLEN-1:0]  lsu_data;
  logic             lsu_ready;

  logic             issue_valid;
  logic [IDX_W-1:0] issue_rd;
  logic             issue_ready;

  logic [IDX_W-1:0] rs1;
  logic [IDX_W-1:0] rs2;
  logic             rs1_busy;
  logic             rs2_busy;

  logic             rf_write;
  logic [IDX_W-1:0] rf_rd;
  logic [XLEN-1:0]  rf_rddata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output issue_valid, issue_rd,
    input  issue_ready,
    output rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  rf_write, rf_rd, rf_rddata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  rs1, rs2,
    output rs1_busy, rs2_busy,
    output rf_write, rf_rd, rf_rddata
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//   Write-back scheduler for the integer register file. Arbitrates the single
//   register-file write port between the ALU and the LSU, registers the
//   selected write, and keeps a pending-write scoreboard for RAW/WAW stalls.
//
//   Ports
//     clk    rising-edge clock shared with the register file
//     clr_n  asynchronous active-low reset
//     wb     regfile_wb_sched_if.slave (requests, issue, hazard query,
//            register-file write port)
//
//   Configuration macro
//     WB_RR_ARB_EN  defined   : round-robin between ALU and LSU on contention
//                   undefined : fixed priority, LSU wins on contention
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  regfile_wb_sched_if.slave wb
);
  localparam int IDX_W = $clog2(NREG);

  logic             alu_gnt;
  logic             lsu_gnt;
  logic             gnt_any;
  logic [IDX_W-1:0] gnt_rd;
  logic [XLEN-1:0]  gnt_data;

  logic             rf_write_q, rf_write_d;
  logic [IDX_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_rddata_q, rf_rddata_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             issue_ready;
  logic             issue_fire;

`ifdef WB_RR_ARB_EN
  typedef enum logic {ALU_FAV, LSU_FAV} arb_state_e;
  arb_state_e arb_q, arb_d;

  // After any grant the pointer favours the requester that did not win,
  // which for a contended grant is the loser.
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    arb_d   = arb_q;
    if (wb.alu_valid && wb.lsu_valid) begin
      if (arb_q == ALU_FAV) begin
        alu_gnt = 1'b1;
        arb_d   = LSU_FAV;
      end else begin
        lsu_gnt = 1'b1;
        arb_d   = ALU_FAV;
      end
    end else if (wb.alu_valid) begin
      alu_gnt = 1'b1;
      arb_d   = LSU_FAV;
    end else if (wb.lsu_valid) begin
      lsu_gnt = 1'b1;
      arb_d   = ALU_FAV;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) arb_q <= ALU_FAV;
    else        arb_q <= arb_d;
  end
`else
  // Fixed priority: LSU load data never waits behind the ALU.
  always_comb begin
    lsu_gnt = wb.lsu_valid;
    alu_gnt = wb.alu_valid & ~wb.lsu_valid;
  end
`endif

  assign wb.alu_ready = alu_gnt;
  assign wb.lsu_ready = lsu_gnt;

  // A grant to x0 is consumed but never reaches the register file.
  always_comb begin
    gnt_any     = alu_gnt | lsu_gnt;
    gnt_rd      = lsu_gnt ? wb.lsu_rd   : wb.alu_rd;
    gnt_data    = lsu_gnt ? wb.lsu_data : wb.alu_data;
    rf_write_d  = gnt_any && (gnt_rd != '0);
    rf_rd_d     = rf_rd_q;
    rf_rddata_d = rf_rddata_q;
    if (gnt_any) begin
      rf_rd_d     = gnt_rd;
      rf_rddata_d = gnt_data;
    end
  end

  assign issue_ready = ~busy_q[wb.issue_rd];
  assign issue_fire  = wb.issue_valid && issue_ready && (wb.issue_rd != '0);

  // Clear for the write leaving the port this edge, then set for a new
  // reservation so that a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (rf_write_q) busy_d[rf_rd_q] = 1'b0;
    if (issue_fire) busy_d[wb.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rf_write_q  <= 1'b0;
      rf_rd_q     <= '0;
      rf_rddata_q <= '0;
      busy_q      <= '0;
    end else begin
      rf_write_q  <= rf_write_d;
      rf_rd_q     <= rf_rd_d;
      rf_rddata_q <= rf_rddata_d;
      busy_q      <= busy_d;
    end
  end

  assign wb.issue_ready = issue_ready;
  assign wb.rs1_busy    = busy_q[wb.rs1];
  assign wb.rs2_busy    = busy_q[wb.rs2];
  assign wb.rf_write    = rf_write_q;
  assign wb.rf_rd       = rf_rd_q;
  assign wb.rf_rddata   = rf_rddata_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  regfile_wb_sched_if #(.XLEN(XLEN), .NREG(NREG)) wb ();

  regfile_wb_sched #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .wb    (wb)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set of destination registers, a favour flag and
  // the last write-back handed to the register file.
  bit          m_busy [NREG];
  bit          m_write;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
`ifdef WB_RR_ARB_EN
  bit          m_fav_alu;
`endif

  always @(negedge clk) begin
    bit          ea, el, eir;
    bit          nb [NREG];
    logic [4:0]  grd;
    if (!clr_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_write = 1'b0;
      m_rd    = '0;
      m_data  = '0;
`ifdef WB_RR_ARB_EN
      m_fav_alu = 1'b1;
`endif
    end
    if (wb.alu_valid && wb.lsu_valid) begin
`ifdef WB_RR_ARB_EN
      ea = m_fav_alu;
      el = !m_fav_alu;
`else
      ea = 1'b0;
      el = 1'b1;
`endif
    end else begin
      ea = wb.alu_valid;
      el = wb.lsu_valid;
    end
    eir = !m_busy[wb.issue_rd];
    check("alu_ready",   wb.alu_ready,   ea);
    check("lsu_ready",   wb.lsu_ready,   el);
    check("issue_ready", wb.issue_ready, eir);
    check("rs1_busy",    wb.rs1_busy,    m_busy[wb.rs1]);
    check("rs2_busy",    wb.rs2_busy,    m_busy[wb.rs2]);
    check("rf_write",    wb.rf_write,    m_write);
    check("rf_rd",       wb.rf_rd,       m_rd);
    check("rf_rddata",   wb.rf_rddata,   m_data);
    if (clr_n) begin
      nb = m_busy;
      if (m_write) nb[m_rd] = 1'b0;
      if (wb.issue_valid && eir && wb.issue_rd != 0) nb[wb.issue_rd] = 1'b1;
      nb[0] = 1'b0;
      m_busy = nb;
      if (ea || el) begin
        grd     = el ? wb.lsu_rd : wb.alu_rd;
        m_write = (grd != 0);
        m_rd    = grd;
        m_data  = el ? wb.lsu_data : wb.alu_data;
`ifdef WB_RR_ARB_EN
        m_fav_alu = el;
`endif
      end else begin
        m_write = 1'b0;
      end
    end
  end

  task automatic idle();
    wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = 0;
    wb.lsu_valid = 0; wb.lsu_rd = 0; wb.lsu_data = 0;
    wb.issue_valid = 0; wb.issue_rd = 0;
    wb.rs1 = 0; wb.rs2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 9) < 8) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a_done, l_done;
    clr_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;

    // Idle sweep over every register index.
    for (int i = 0; i < NREG; i++) begin
      wb.rs1 = 5'(i);
      wb.rs2 = 5'(NREG - 1 - i);
      wb.issue_rd = 5'(i);
      @(negedge clk);
      check("idle_rs1_busy", wb.rs1_busy, 1'b0);
      check("idle_rs2_busy", wb.rs2_busy, 1'b0);
      check("idle_issue_ready", wb.issue_ready, 1'b1);
      check("idle_rf_write", wb.rf_write, 1'b0);
      step();
    end
    idle();
    @(negedge clk);
    check("idle_rf_rd", wb.rf_rd, 5'd0);
    check("idle_rf_rddata", wb.rf_rddata, 32'd0);
    step();

    // Continuous contention for 4 cycles.
    wb.alu_valid = 1; wb.alu_rd = 5'd1; wb.alu_data = 32'hA1A1_A1A1;
    wb.lsu_valid = 1; wb.lsu_rd = 5'd2; wb.lsu_data = 32'hB2B2_B2B2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef WB_RR_ARB_EN
      check("contend_alu_ready", wb.alu_ready, (i % 2 == 0));
      check("contend_lsu_ready", wb.lsu_ready, (i % 2 == 1));
      if (i > 0) check("contend_rf_rd", wb.rf_rd, (i % 2 == 1) ? 5'd1 : 5'd2);
`else
      check("contend_alu_ready", wb.alu_ready, 1'b0);
      check("contend_lsu_ready", wb.lsu_ready, 1'b1);
      if (i > 0) check("contend_rf_rd", wb.rf_rd, 5'd2);
`endif
      step();
    end
    idle();
    step();

    // ALU-only write of 0xDEADBEEF to x5.
    wb.alu_valid = 1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("alu_only_ready", wb.alu_ready, 1'b1);
    step();
    wb.alu_valid = 0;
    @(negedge clk);
    check("alu_only_rf_write", wb.rf_write, 1'b1);
    check("alu_only_rf_rd", wb.rf_rd, 5'd5);
    check("alu_only_rf_rddata", wb.rf_rddata, 32'hDEAD_BEEF);
    step();

    // Reserve x7, query it, retry issue, then retire it through the LSU.
    wb.issue_valid = 1; wb.issue_rd = 5'd7;
    @(negedge clk);
    check("issue7_ready", wb.issue_ready, 1'b1);
    step();
    wb.rs1 = 5'd7;
    @(negedge clk);
    check("issue7_rs1_busy", wb.rs1_busy, 1'b1);
    check("issue7_waw_ready", wb.issue_ready, 1'b0);
    step();
    wb.issue_valid = 0;
    wb.lsu_valid = 1; wb.lsu_rd = 5'd7; wb.lsu_data = 32'h0000_0077;
    @(negedge clk);
    check("lsu7_ready", wb.lsu_ready, 1'b1);
    step();
    wb.lsu_valid = 0;
    @(negedge clk);
    check("lsu7_rf_write", wb.rf_write, 1'b1);
    check("lsu7_busy_until_edge", wb.rs1_busy, 1'b1);
    step();
    @(negedge clk);
    check("lsu7_busy_cleared", wb.rs1_busy, 1'b0);
    step();

    // Issue and write-back targeting x0.
    wb.issue_valid = 1; wb.issue_rd = 5'd0;
    @(negedge clk);
    check("x0_issue_ready", wb.issue_ready, 1'b1);
    step();
    wb.issue_valid = 0; wb.rs1 = 5'd0;
    wb.alu_valid = 1; wb.alu_rd = 5'd0; wb.alu_data = 32'h0000_1234;
    @(negedge clk);
    check("x0_rs1_busy", wb.rs1_busy, 1'b0);
    check("x0_alu_ready", wb.alu_ready, 1'b1);
    step();
    wb.alu_valid = 0;
    @(negedge clk);
    check("x0_rf_write", wb.rf_write, 1'b0);
    step();

    // Reset arriving the cycle after a grant.
    wb.issue_valid = 1; wb.issue_rd = 5'd12;
    step();
    wb.issue_valid = 0; wb.rs1 = 5'd12; wb.rs2 = 5'd9;
    wb.alu_valid = 1; wb.alu_rd = 5'd9; wb.alu_data = 32'h0000_0099;
    @(negedge clk);
    check("rst_pre_busy12", wb.rs1_busy, 1'b1);
    check("rst_pre_alu_ready", wb.alu_ready, 1'b1);
    step();
    wb.alu_valid = 0;
    check("rst_pre_rf_write", wb.rf_write, 1'b1);
    #1 clr_n = 1'b0;
    #1;
    check("rst_rf_write_drop", wb.rf_write, 1'b0);
    check("rst_rf_rd", wb.rf_rd, 5'd0);
    check("rst_rf_rddata", wb.rf_rddata, 32'd0);
    check("rst_busy12", wb.rs1_busy, 1'b0);
    @(negedge clk);
    check("rst_busy9", wb.rs2_busy, 1'b0);
    step();
    clr_n = 1'b1;
    idle();
    step();

    // Randomized traffic honouring the hold-until-ready rule.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_done = wb.alu_valid & wb.alu_ready;
      l_done = wb.lsu_valid & wb.lsu_ready;
      step();
      if (!wb.alu_valid || a_done) begin
        wb.alu_valid = ($urandom_range(0, 9) < 6);
        wb.alu_rd    = rnd_rd();
        wb.alu_data  = $urandom;
      end
      if (!wb.lsu_valid || l_done) begin
        wb.lsu_valid = ($urandom_range(0, 9) < 6);
        wb.lsu_rd    = rnd_rd();
        wb.lsu_data  = $urandom;
      end
      wb.issue_valid = 1'($urandom_range(0, 1));
      wb.issue_rd    = rnd_rd();
      wb.rs1         = rnd_rd();
      wb.rs2         = rnd_rd();
    end
    idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the 32 x 32-bit integer register file. It arbitrates the single register-file write port between the ALU write-back path and the load/store unit (LSU) using valid/ready handshakes, and drives the port's `write`, `rd` and `rddata` inputs from registers. It also keeps a pending-write scoreboard so the issue stage can stall on RAW and WAW hazards. It sits between the execute/memory units and the register file, and feeds busy flags back to decode.

## Interface
- `XLEN`, 32, data width of the write-back path.
- `NREG`, 32, number of architectural registers (index width log2(NREG) = 5).

- `clk`  in  1  rising-edge clock, shared with the register file.
- `clr_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU has a result to write.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU request granted this cycle.
- `lsu_valid`  in  1  LSU has load data to write.
- `lsu_rd`  in  5  LSU destination register.
- `lsu_data`  in  XLEN  load data.
- `lsu_ready`  out  1  LSU request granted this cycle.
- `issue_valid`  in  1  decode is issuing an instruction that writes `issue_rd`.
- `issue_rd`  in  5  destination register of the issuing instruction.
- `issue_ready`  out  1  issue accepted (no WAW conflict).
- `rs1`, `rs2`  in  5 each  source indices being decoded.
- `rs1_busy`, `rs2_busy`  out  1 each  source has a write pending.
- `rf_write`  out  1  register-file write enable.
- `rf_rd`  out  5  register-file write index.
- `rf_rddata`  out  XLEN  register-file write data.

## Operation
- Reset (`clr_n` = 0, asynchronous): `rf_write` = 0, `rf_rd` = 0, `rf_rddata` = 0, scoreboard cleared to 0, arbitration pointer = ALU-favoured.
- Arbitration is combinational. A grant is given when exactly one requester is valid, or by the pointer when both are valid. `alu_ready` and `lsu_ready` are one-hot or both 0. A transfer completes when valid and ready are both high in the same cycle.
- Requester rule: hold `*_valid`, `*_rd` and `*_data` stable until ready is seen.
- Arbiter state: two states, ALU_FAV and LSU_FAV. On a contended grant, the pointer moves to favour the loser. On an uncontended grant, the pointer moves to favour the other requester. With no grant, the pointer holds.
- Registered write-back: on a grant, the next cycle has `rf_write` = 1, `rf_rd` = granted rd, `rf_rddata` = granted data. A grant with rd = 0 is consumed but gives `rf_write` = 0. With no grant, `rf_write` = 0 and `rf_rd`/`rf_rddata` hold their last values.
- Scoreboard: one busy bit per register. Bit 0 is hard-wired to 0.
  - Set: the bit for `issue_rd` is set when `issue_valid & issue_ready` and `issue_rd` != 0.
  - Clear: the bit for `rf_rd` is cleared on the edge where `rf_write` = 1.
  - Simultaneous set and clear of the same index: set wins.
- `issue_ready` = !busy[`issue_rd`]. It is always 1 for `issue_rd` = 0.
- `rs1_busy` = busy[`rs1`] and `rs2_busy` = busy[`rs2`], combinational, from the current scoreboard state.
- No write-back is ever dropped. At most one write per cycle.

## Timing
- Grant to `rf_write` = 1: 1 cycle. The register file captures the data on the following edge, which is the same edge that clears busy.
- Issue to busy visible on `rs*_busy`: 1 cycle.
- A write request back-to-back with issue of the same rd: busy sets, then clears normally. The requester must not present the write before the issue edge.
- Throughput: 1 write per cycle. Under continuous contention each requester gets 1 grant every 2 cycles.
- Reset asserted mid-operation: an in-flight `rf_write` is dropped and all busy bits clear. Requesters must re-present after reset.

## Configuration
- `WB_RR_ARB_EN` defined: round-robin pointer as described above.
- `WB_RR_ARB_EN` undefined: fixed priority, LSU always wins when both are valid. The pointer state is removed. The ALU may starve; upstream guarantees LSU bursts stay below 8 cycles.

## Test plan
- Reset, then idle: all outputs 0, `issue_ready` = 1, `rs1_busy` = `rs2_busy` = 0 for every index.
- ALU-only write, rd = 5, data 0xDEADBEEF: `alu_ready` = 1 in cycle N; in cycle N+1 `rf_write` = 1, `rf_rd` = 5, `rf_rddata` = 0xDEADBEEF.
- Both valid for 4 cycles with `WB_RR_ARB_EN`: grants alternate ALU, LSU, ALU, LSU. Without the macro: LSU wins all 4 cycles.
- Issue rd = 7, then query rs1 = 7: `rs1_busy` = 1 the next cycle. A second issue of rd = 7 sees `issue_ready` = 0. An LSU write to rd = 7 clears busy one cycle after the grant.
- Issue and write-back to rd = 0: no busy bit is set, `rf_write` stays 0, and the grant is still consumed.
- `clr_n` pulled low in the cycle after a grant: `rf_write` drops to 0 immediately and the scoreboard reads all-zero.
